lsu: RTL
========

Name: lsu

Overview:
- Load/store unit between the execute stage and the byte-addressed data RAM.
- Accepts one RV32I load or store per handshake, checks it, and drives the RAM read/write ports with byte strobes for exactly one cycle.
- For loads, masks and sign- or zero-extends the returned lanes.
- Returns a result or a fault to writeback through a valid/ready response channel.

Parameters:
- MEM_BYTES, 256, size of the attached RAM in bytes; any access with a byte beyond MEM_BYTES-1 faults.
- ALLOW_MISALIGNED, 1'b0, when 0 a halfword at an odd address or a word at an address not divisible by 4 faults; when 1 it is forwarded, since the RAM addresses lanes as addr+k.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- req_addr  in  32  effective byte address
- req_wdata  in  32  store data (rs2)
- resp_valid  out  1  response present
- resp_ready  in  1  writeback accepts the response
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  request faulted; memory was not touched
- resp_cause  out  2  0 none, 1 misaligned, 2 out of range, 3 illegal funct3
- mem_read_addr  out  32  RAM read address
- mem_write_addr  out  32  RAM write address
- mem_read_enable  out  1  RAM read enable
- mem_write_enable  out  1  RAM write enable
- mem_write_data  out  32  lane k is written to addr+k
- mem_write_strb  out  4  write lane enables
- mem_read_strb  out  4  read lane enables
- mem_read_data  in  32  combinational RAM read data; lanes with strobe off are undefined

Behaviour:
- States: IDLE, MEM, RESP. Reset puts the unit in IDLE with every output 0 and req_ready=1 once rst falls.
- Outputs in IDLE: req_ready=1; all mem_* outputs 0.
- Request accepted when req_valid && req_ready. The unit latches op, addr and wdata, then runs the checks in priority order:
  - illegal funct3 (load 011/110/111; store with funct3 >= 011) -> cause 3
  - misaligned -> cause 1
  - addr + size - 1 >= MEM_BYTES, computed 33 bits wide so wrap-around at 0xFFFFFFFF faults -> cause 2
- Fault path: go to RESP with resp_fault=1 and the cause set. No mem enable is ever asserted.
- OK path: go to MEM.
- MEM, exactly one cycle:
  - read_addr = write_addr = latched addr.
  - strb: 0001 for byte, 0011 for half, 1111 for word.
  - Loads: mem_read_enable=1 and mem_read_strb=strb; mem_read_data is sampled at the end of the cycle.
  - Stores: mem_write_enable=1, mem_write_strb=strb, mem_write_data = latched wdata unshifted; lanes outside strb are driven 0.
  - All mem enables are gated by !rst, so a reset asserted during MEM performs no write.
- Load formatting:
  - Mask lanes outside strb.
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: pass through.
  - The result is registered into resp_rdata.
- RESP: resp_valid=1 with rdata, fault and cause held stable until resp_ready. On resp_valid && resp_ready, go to IDLE.
- No new request is accepted in the handoff cycle, so req_ready rises the cycle after the response is taken.
- Latency from acceptance at cycle N:
  - OK path: resp_valid at N+2.
  - Fault path: resp_valid at N+1.
  - Minimum issue interval: 3 cycles.
- req_ready=0 in MEM and RESP. Request inputs are ignored there; the upstream stage holds them.
- Reset in any state returns the unit to IDLE on the next edge, drops resp_valid, and discards the in-flight transaction.

Decomposition:
- Package lsu_pkg holds:
  - state enum lsu_state_t (IDLE, MEM, RESP)
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU
  - cause enum lsu_cause_t (CAUSE_NONE, CAUSE_MISALIGN, CAUSE_RANGE, CAUSE_ILLEGAL)
  - function size_to_strb
- Sub-module lsu_load_fmt: combinational mask and extend. Inputs are funct3 and raw data; output is the 32-bit result.

Test Plan:
- SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> write_strb 1111 in the MEM cycle; the load returns resp_rdata 0xDEADBEEF at N+2 with resp_fault=0.
- SB 0x21 data 0x80, then LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080. Other bytes of that word are unchanged.
- LH at 0x13 with ALLOW_MISALIGNED=0 -> resp_fault=1, cause 1, resp_valid at N+1, no enable pulse.
- With ALLOW_MISALIGNED=1: LW 0xFD -> cause 2; LW 0xFFFFFFFE -> cause 2; LB funct3 011 -> cause 3.
- Hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stay stable and req_ready stays 0. After the response is taken, req_ready=1 one cycle later.
- Assert rst during the MEM cycle of an SW to 0x40 -> no write occurs (a later LW 0x40 returns the old value), resp_valid stays 0, and the unit is in IDLE after the edge.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
//   lsu_state_t   : control state (IDLE -> MEM -> RESP, or IDLE -> RESP on a fault)
//   lsu_cause_t   : fault cause reported with a response
//   F3_*          : RV32I load/store funct3 encodings
//   size_to_strb  : lane-enable mask for a funct3 size field (byte/half/word)
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_RANGE    = 2'd2,
        CAUSE_ILLEGAL  = 2'd3
    } lsu_cause_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] encodes the access size for every legal load and store.
    function automatic logic [3:0] size_to_strb(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load result formatting: masks the lanes the access did not read, then
// sign- or zero-extends according to funct3.
//   funct3_i : load funct3 (LB/LH/LW/LBU/LHU)
//   raw_i    : RAM read data, lanes outside the access are undefined
//   result_o : 32-bit value for the destination register
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] raw_i,
    output logic [31:0] result_o
);

    logic [3:0]  strb;
    logic [31:0] masked;

    always_comb begin
        strb   = size_to_strb(funct3_i[1:0]);
        masked = raw_i & {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        case (funct3_i)
            F3_B:    result_o = {{24{masked[7]}}, masked[7:0]};
            F3_H:    result_o = {{16{masked[15]}}, masked[15:0]};
            F3_W:    result_o = masked;
            F3_BU:   result_o = {24'h0, masked[7:0]};
            F3_HU:   result_o = {16'h0, masked[15:0]};
            default: result_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit between execute and a byte-addressed data RAM.
//   req_*   : one RV32I load/store per valid/ready handshake
//   resp_*  : result or fault back to writeback, valid/ready
//   mem_*   : RAM read/write ports, active for exactly the one MEM cycle
// Requests are checked at acceptance; a faulting request never reaches MEM,
// so the RAM is untouched and the response appears one cycle after accept.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES        = 256,
    parameter bit          ALLOW_MISALIGNED = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [1:0]  resp_cause,
    output logic [31:0] mem_read_addr,
    output logic [31:0] mem_write_addr,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_strb,
    output logic [3:0]  mem_read_strb,
    input  logic [31:0] mem_read_data
);

    lsu_state_t  state_q;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        fault_q;
    lsu_cause_t  cause_q;

    logic        illegal_d;
    logic        misalign_d;
    logic        range_d;
    logic [1:0]  size_m1_d;
    logic [32:0] last_byte_d;
    lsu_cause_t  cause_d;
    logic [31:0] load_result;

    // Request checks, evaluated on the live request inputs at acceptance.
    always_comb begin
        if (req_is_store) illegal_d = (req_funct3 >= 3'b011);
        else              illegal_d = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);

        case (req_funct3[1:0])
            2'b00:   size_m1_d = 2'd0;
            2'b01:   size_m1_d = 2'd1;
            default: size_m1_d = 2'd3;
        endcase

        misalign_d = !ALLOW_MISALIGNED &&
                     (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));

        // 33-bit sum so an access wrapping past 0xFFFFFFFF is caught as out of range.
        last_byte_d = {1'b0, req_addr} + {31'h0, size_m1_d};
        range_d     = (last_byte_d >= 33'(MEM_BYTES));

        cause_d = CAUSE_NONE;
        if (illegal_d)      cause_d = CAUSE_ILLEGAL;
        else if (misalign_d) cause_d = CAUSE_MISALIGN;
        else if (range_d)    cause_d = CAUSE_RANGE;
    end

    lsu_load_fmt u_load_fmt (
        .funct3_i (funct3_q),
        .raw_i    (mem_read_data),
        .result_o (load_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        is_store_q <= req_is_store;
                        funct3_q   <= req_funct3;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        rdata_q    <= 32'h0;
                        cause_q    <= cause_d;
                        fault_q    <= (cause_d != CAUSE_NONE);
                        state_q    <= (cause_d != CAUSE_NONE) ? RESP : MEM;
                    end
                end
                MEM: begin
                    // RAM read data is combinational and sampled at the end of MEM.
                    rdata_q <= is_store_q ? 32'h0 : load_result;
                    state_q <= RESP;
                end
                RESP: begin
                    if (resp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic        in_mem;
    logic [3:0]  strb;
    logic [31:0] lane_mask;

    always_comb begin
        in_mem    = (state_q == MEM);
        strb      = size_to_strb(funct3_q[1:0]);
        lane_mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;
    assign resp_cause = cause_q;

    // Enables are gated by rst so a reset landing in MEM cannot commit a write.
    assign mem_read_enable  = in_mem && !is_store_q && !rst;
    assign mem_write_enable = in_mem &&  is_store_q && !rst;
    assign mem_read_addr    = in_mem ? addr_q : 32'h0;
    assign mem_write_addr   = in_mem ? addr_q : 32'h0;
    assign mem_read_strb    = (in_mem && !is_store_q) ? strb : 4'h0;
    assign mem_write_strb   = (in_mem &&  is_store_q) ? strb : 4'h0;
    assign mem_write_data   = (in_mem &&  is_store_q) ? (wdata_q & lane_mask) : 32'h0;

endmodule
